// File: rtl/pingpang_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pingpang_ctrl
// Description : Ping-pong (double) buffer controller. Two writers (A and B)
//               compete for the write side. The granted writer fills one bank
//               of DEPTH beats, one frame at a time. A single reader drains
//               full banks in the order they were written.
//               Arbitration mode is selected by the PINGPANG_RR_EN macro:
//                 defined   -> round-robin between A and B
//                 undefined -> fixed priority, A over B (default build)
// Ports       : clk            - clock, rising edge
//               rst_n          - asynchronous active-low reset
//               req_a/req_b    - frame write requests from sources A/B
//               gnt_a/gnt_b    - registered grant, held for a whole frame
//               wr_vld/wr_rdy  - write beat handshake of the granted source
//               wr_en          - buffer write strobe (wr_vld & wr_rdy)
//               wr_bank        - bank being written
//               wr_addr        - beat address inside the write bank
//               rd_vld/rd_rdy  - read beat handshake with the consumer
//               rd_bank        - bank being read
//               rd_addr        - beat address inside the read bank
//               rd_src         - source of the frame in rd_bank (0=A, 1=B)
//               bank_full      - per-bank full flags
// Revision    : 1.0 - initial release
// ============================================================================
module pingpang_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  output logic          gnt_a,
  output logic          gnt_b,
  input  logic          wr_vld,
  output logic          wr_rdy,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          rd_src,
  output logic [1:0]    bank_full
);

  localparam logic          W_IDLE      = 1'b0;
  localparam logic          W_FILL      = 1'b1;
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

  logic          state_q,   state_d;
  logic          gnt_a_q,   gnt_a_d;
  logic          gnt_b_q,   gnt_b_d;
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]    full_q,    full_d;
  logic [1:0]    tag_q,     tag_d;

  logic w_arb_ok;
  logic w_pick_b;
  logic w_wr_last;
  logic w_rd_fire;
  logic w_rd_last;

  // A new frame may only start into an empty bank; requests are only looked
  // at while idle, so dropping a request mid-frame has no effect.
  assign w_arb_ok  = (state_q == W_IDLE) & ~full_q[wr_bank_q] & (req_a | req_b);
  assign w_wr_last = wr_en & (wr_addr_q == c_last_addr);
  assign w_rd_fire = rd_vld & rd_rdy;
  assign w_rd_last = w_rd_fire & (rd_addr_q == c_last_addr);

`ifdef PINGPANG_RR_EN
  // ptr_q = 0 favours A, 1 favours B; it only matters on simultaneous requests.
  logic ptr_q, ptr_d;

  assign w_pick_b = req_b & (~req_a | ptr_q);
  assign ptr_d    = w_arb_ok ? ~w_pick_b : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign w_pick_b = ~req_a;
`endif

  // --------------------------------------------------------------------------
  // Write FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= W_IDLE;
    else        state_q <= state_d;
  end

  // Write FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (w_arb_ok)  state_d = W_FILL;
      W_FILL:  if (w_wr_last) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    wr_rdy = (state_q == W_FILL);
  end

  // --------------------------------------------------------------------------
  // Grant, bank pointers, addresses, full flags and source tags
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_a_d   = gnt_a_q;
    gnt_b_d   = gnt_b_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    full_d    = full_q;
    tag_d     = tag_q;

    if (w_arb_ok) begin
      gnt_a_d = ~w_pick_b;
      gnt_b_d = w_pick_b;
    end

    if (w_wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      tag_d[wr_bank_q]  = gnt_b_q;   // granted source: 0=A, 1=B
      wr_bank_d         = ~wr_bank_q;
      wr_addr_d         = '0;
      gnt_a_d           = 1'b0;
      gnt_b_d           = 1'b0;
    end else if (wr_en) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    // The write bank is never full and the read bank always is while reading,
    // so a write-complete and a read-complete in one cycle touch different
    // flag bits and both take effect.
    if (w_rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      rd_addr_d         = '0;
    end else if (w_rd_fire) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      full_q    <= 2'b00;
      tag_q     <= 2'b00;
    end else begin
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      full_q    <= full_d;
      tag_q     <= tag_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign wr_en     = wr_vld & wr_rdy;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign rd_vld    = full_q[rd_bank_q];
  assign rd_bank   = rd_bank_q;
  assign rd_addr   = rd_addr_q;
  assign rd_src    = tag_q[rd_bank_q];
  assign bank_full = full_q;

endmodule
`default_nettype wire

// File: tb/tb_pingpang_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpang_ctrl
// Description : Self-checking bench for pingpang_ctrl (DEPTH=4). A frame-level
//               reference model (queue of buffered frames, beat counters and
//               the current owner) predicts every output each cycle. Directed
//               sequences cover the documented scenarios, then random traffic.
//               Build with +define+PINGPANG_RR_EN to check round-robin mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpang_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          req_a  = 1'b0;
  logic          req_b  = 1'b0;
  logic          wr_vld = 1'b0;
  logic          rd_rdy = 1'b0;
  logic          gnt_a, gnt_b, wr_rdy, wr_en, wr_bank;
  logic          rd_vld, rd_bank, rd_src;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    bank_full;

  pingpang_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .wr_vld    (wr_vld),
    .wr_rdy    (wr_rdy),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .rd_vld    (rd_vld),
    .rd_rdy    (rd_rdy),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .rd_src    (rd_src),
    .bank_full (bank_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model state
  int owner;          // -1 none, 0 A, 1 B
  int nfw, nfr;       // frames written / read since reset
  int wbeats, rbeats; // beats done in the current write / read frame
  int src_q[$];       // sources of buffered frames, oldest first
  int last_src[2];    // last source written into each bank
  int rr_next;        // source favoured on a tie (round-robin mode)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; nfw = 0; nfr = 0; wbeats = 0; rbeats = 0;
    src_q.delete(); last_src[0] = 0; last_src[1] = 0; rr_next = 0;
  endtask

  task automatic compare_all();
    int exp_bf;
    int exp_src;
    exp_bf = 0;
    for (int i = 0; i < src_q.size(); i++) exp_bf |= 1 << ((nfr + i) % 2);
    exp_src = (src_q.size() > 0) ? src_q[0] : last_src[nfr % 2];
    check("gnt_a",     32'(gnt_a),     32'(owner == 0));
    check("gnt_b",     32'(gnt_b),     32'(owner == 1));
    check("wr_rdy",    32'(wr_rdy),    32'(owner != -1));
    check("wr_en",     32'(wr_en),     32'((owner != -1) && wr_vld));
    check("wr_bank",   32'(wr_bank),   32'(nfw % 2));
    check("wr_addr",   32'(wr_addr),   32'(wbeats));
    check("rd_vld",    32'(rd_vld),    32'(src_q.size() > 0));
    check("rd_bank",   32'(rd_bank),   32'(nfr % 2));
    check("rd_addr",   32'(rd_addr),   32'(rbeats));
    check("rd_src",    32'(rd_src),    32'(exp_src));
    check("bank_full", 32'(bank_full), 32'(exp_bf));
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    int  sz;
    int  pick;
    bit  do_push;
    int  psrc;
    sz      = src_q.size();
    do_push = 1'b0;
    psrc    = 0;
    if (owner == -1) begin
      if (sz < 2 && (req_a || req_b)) begin
`ifdef PINGPANG_RR_EN
        if (req_a && req_b) pick = rr_next;
        else                pick = req_b ? 1 : 0;
        rr_next = 1 - pick;
`else
        pick = req_a ? 0 : 1;
`endif
        owner = pick;
      end
    end else if (wr_vld) begin
      wbeats++;
      if (wbeats == DEPTH) begin
        do_push = 1'b1;
        psrc    = owner;
      end
    end
    if (sz > 0 && rd_rdy) begin
      rbeats++;
      if (rbeats == DEPTH) begin
        void'(src_q.pop_front());
        nfr++;
        rbeats = 0;
      end
    end
    if (do_push) begin
      src_q.push_back(psrc);
      last_src[nfw % 2] = psrc;
      nfw++;
      wbeats = 0;
      owner  = -1;
    end
  endtask

  task automatic cycle(input logic a, input logic b, input logic v, input logic r);
    @(negedge clk);
    req_a = a; req_b = b; wr_vld = v; rd_rdy = r;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; wr_vld = 1'b0; rd_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int prev_g;
    int g;
    int seq[4];

    model_reset();
    do_reset();

    // Single frame from A, reader stalled
    cycle(1, 0, 1, 0);
    repeat (4) cycle(1, 0, 1, 0);
    #2;
    check("f1_bank_full", 32'(bank_full), 32'h1);
    check("f1_wr_bank",   32'(wr_bank),   32'h1);
    check("f1_rd_vld",    32'(rd_vld),    32'h1);
    check("f1_rd_src",    32'(rd_src),    32'h0);

    // Write-complete on bank 1 coinciding with read-complete on bank 0;
    // request dropped mid-frame must not release the grant
    cycle(1, 0, 1, 0);
    repeat (4) cycle(0, 0, 1, 1);
    #2;
    check("swap_bank_full", 32'(bank_full), 32'h2);

    // Fill to both-full, writer must wait, then re-grant after a read frame
    repeat (5) cycle(1, 0, 1, 0);
    #2;
    check("both_full", 32'(bank_full), 32'h3);
    repeat (3) cycle(1, 0, 1, 0);
    #2;
    check("full_no_gnt", 32'(gnt_a), 32'h0);
    repeat (4) cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 0);
    #2;
    check("regrant", 32'(gnt_a), 32'h1);
    repeat (4) cycle(0, 0, 1, 0);

    // Stuttering write valid with a ready reader
    for (int i = 0; i < 14; i++) cycle(1, 0, logic'(i % 2 == 0), 1);

    // Asynchronous reset in the middle of a frame
    do_reset();
    repeat (5) cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    repeat (2) cycle(0, 0, 1, 0);
    @(negedge clk);
    #2;
    check("pre_rst_wr_addr", 32'(wr_addr),   32'h2);
    check("pre_rst_full",    32'(bank_full), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_gnt",  32'({gnt_a, gnt_b}), 32'h0);
    check("rst_wr",   32'({wr_rdy, wr_en, wr_bank, wr_addr}), 32'h0);
    check("rst_rd",   32'({rd_vld, rd_bank, rd_addr, rd_src}), 32'h0);
    check("rst_full", 32'(bank_full), 32'h0);
    model_reset();
    req_a = 1'b0; req_b = 1'b0; rd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 1, 1);

    // Simultaneous requests, reader always ready: record grant order
    got = 0;
    prev_g = 0;
    for (int i = 0; i < 60 && got < 4; i++) begin
      cycle(1, 1, 1, 1);
      #1;
      g = gnt_a ? 1 : (gnt_b ? 2 : 0);
      if (g != 0 && prev_g == 0) begin
        seq[got] = g;
        got++;
      end
      prev_g = g;
    end
    check("tie_grant_count", 32'(got), 32'd4);
    for (int k = 0; k < got; k++) begin
`ifdef PINGPANG_RR_EN
      check($sformatf("tie_grant%0d", k), 32'(seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
`else
      check($sformatf("tie_grant%0d", k), 32'(seq[k]), 32'd1);
`endif
    end

    // Random traffic with varying reader pressure
    for (int i = 0; i < 3000; i++) begin
      int rd_bias;
      rd_bias = (i / 500) % 3;
      cycle(logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 3) < 1 + rd_bias));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
